// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer (master) and the LEGv8
// datapath (slave): datapath status in, strobes and selects out.
interface multicycle_control_if;
   logic [31:0] iInstruction;
   logic        iZero;
   logic        iMemReady;
   logic        IRWrite;
   logic        PCWrite;
   logic        PCWriteCond;
   logic        IorD;
   logic        MemRead;
   logic        MemWrite;
   logic        MemtoReg;
   logic        RegWrite;
   logic        Reg2Loc;
   logic        PCSource;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ALUOp;
   logic        IllegalOp;
   logic [2:0]  State;
   logic [31:0] InstrCount;

   modport master (
      input  iInstruction, iZero, iMemReady,
      output IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
             RegWrite, Reg2Loc, PCSource, ALUSrcA, ALUSrcB, ALUOp, IllegalOp,
             State, InstrCount
   );

   modport slave (
      output iInstruction, iZero, iMemReady,
      input  IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
             RegWrite, Reg2Loc, PCSource, ALUSrcA, ALUSrcB, ALUOp, IllegalOp,
             State, InstrCount
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, with a retire counter and sticky trap.
module multicycle_control (
   input  logic                 iCLK,
   input  logic                 iRST,
   multicycle_control_if.master bus
);

   typedef enum logic [2:0] {
      FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      CLS_NONE, CLS_R, CLS_LD, CLS_ST, CLS_CBZ, CLS_B, CLS_ILL
   } cls_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg2loc;
      logic       pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
   } ctl_t;

   function automatic cls_e classify(input logic [10:0] op);
      if (op == 11'b10001011000 || op == 11'b11001011000 ||
          op == 11'b10001010000 || op == 11'b10101010000) return CLS_R;
      else if (op == 11'b11111000010) return CLS_LD;
      else if (op == 11'b11111000000) return CLS_ST;
      else if (op[10:3] == 8'b10110100) return CLS_CBZ;
      else if (op[10:5] == 6'b000101) return CLS_B;
      else return CLS_ILL;
   endfunction

   // Moore outputs of a state; the ready-qualified fetch strobes and the
   // DECODE-cycle Reg2Loc are added combinationally below.
   function automatic ctl_t moore_ctl(input state_e s, input cls_e c);
      ctl_t k;
      k = '0;
      case (s)
         FETCH: begin
            k.mem_read  = 1'b1;
            k.alu_src_b = 2'b01;
         end
         DECODE: k.alu_src_b = 2'b11;
         EXEC: begin
            k.reg2loc = (c == CLS_ST) || (c == CLS_CBZ);
            case (c)
               CLS_R: begin
                  k.alu_src_a = 1'b1;
                  k.alu_op    = 2'b10;
               end
               CLS_LD, CLS_ST: begin
                  k.alu_src_a = 1'b1;
                  k.alu_src_b = 2'b10;
               end
               CLS_CBZ: begin
                  k.alu_src_a     = 1'b1;
                  k.alu_op        = 2'b01;
                  k.pc_write_cond = 1'b1;
                  k.pc_source     = 1'b1;
               end
               CLS_B: begin
                  k.pc_write  = 1'b1;
                  k.pc_source = 1'b1;
               end
               default: ;
            endcase
         end
         MEM: begin
            k.ior_d     = 1'b1;
            k.mem_read  = (c == CLS_LD);
            k.mem_write = (c == CLS_ST);
         end
         WB: begin
            k.reg_write  = 1'b1;
            k.mem_to_reg = (c == CLS_LD);
         end
         TRAP:    k.illegal = 1'b1;
         default: ;
      endcase
      return k;
   endfunction

   state_e      state, state_nxt;
   cls_e        cls, cls_nxt;
   ctl_t        ctl, ctl_out;
   logic [31:0] instr_count;
   logic        retire, fetch_ready, decode_reg2loc;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      cls_nxt   = cls;
      case (state)
         FETCH: if (bus.iMemReady) state_nxt = DECODE;
         DECODE: begin
            cls_nxt   = classify(bus.iInstruction[31:21]);
            state_nxt = (cls_nxt == CLS_ILL) ? TRAP : EXEC;
         end
         EXEC: begin
            case (cls)
               CLS_R:          state_nxt = WB;
               CLS_LD, CLS_ST: state_nxt = MEM;
               default:        state_nxt = FETCH;
            endcase
         end
         MEM:     if (bus.iMemReady) state_nxt = (cls == CLS_LD) ? WB : FETCH;
         WB:      state_nxt = FETCH;
         TRAP:    state_nxt = TRAP;
         default: state_nxt = FETCH;
      endcase
   end

   assign retire = (state == EXEC || state == MEM || state == WB) && (state_nxt == FETCH);

   // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state       <= FETCH;
         cls         <= CLS_NONE;
         ctl         <= moore_ctl(FETCH, CLS_NONE);
         instr_count <= '0;
      end else begin
         state       <= state_nxt;
         cls         <= cls_nxt;
         ctl         <= moore_ctl(state_nxt, cls_nxt);
         instr_count <= instr_count + 32'(retire);
      end
   end

   // Reset blanks every output in the same cycle, including mid-access aborts.
   assign ctl_out        = iRST ? ctl_t'('0) : ctl;
   assign fetch_ready    = !iRST && (state == FETCH) && bus.iMemReady;
   assign decode_reg2loc = !iRST && (state == DECODE) &&
                           (cls_nxt == CLS_ST || cls_nxt == CLS_CBZ);

   assign bus.IRWrite     = fetch_ready;
   assign bus.PCWrite     = ctl_out.pc_write | fetch_ready;
   assign bus.PCWriteCond = ctl_out.pc_write_cond;
   assign bus.IorD        = ctl_out.ior_d;
   assign bus.MemRead     = ctl_out.mem_read;
   assign bus.MemWrite    = ctl_out.mem_write;
   assign bus.MemtoReg    = ctl_out.mem_to_reg;
   assign bus.RegWrite    = ctl_out.reg_write;
   assign bus.Reg2Loc     = ctl_out.reg2loc | decode_reg2loc;
   assign bus.PCSource    = ctl_out.pc_source;
   assign bus.ALUSrcA     = ctl_out.alu_src_a;
   assign bus.ALUSrcB     = ctl_out.alu_src_b;
   assign bus.ALUOp       = ctl_out.alu_op;
   assign bus.IllegalOp   = ctl_out.illegal;
   assign bus.State       = iRST ? 3'd0 : 3'(state);
   assign bus.InstrCount  = iRST ? 32'd0 : instr_count;

   // The zero flag and operand fields are consumed by the datapath, not here.
   logic unused_ok;
   assign unused_ok = ^{bus.iZero, bus.iInstruction[20:0]};

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the LEGv8 core. Replaces single-cycle decoding with a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and write-back over several clocks. Drives the shared ALU, register file, instruction register, PC and a single unified memory port with a ready handshake. Also provides a retired-instruction counter and a sticky illegal-opcode trap.

## Interface
- no parameters; opcodes fixed: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100 (bits 31:24), B 000101 (bits 31:26)
- Clock and reset: one clock; reset is synchronous and active-high.
- iCLK  in  1  clock, all state changes on rising edge
- iRST  in  1  synchronous, active-high reset
- iInstruction  in  32  current instruction register contents
- iZero  in  1  ALU zero flag
- iMemReady  in  1  memory completes the current access this cycle
- IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, RegWrite, Reg2Loc  out  1 each  datapath strobes and selects
- PCSource  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = reg B, 01 = constant 4, 10 = D-format sign-extended imm, 11 = branch offset <<2
- ALUOp  out  2  00 add, 01 pass B, 10 funct decode
- IllegalOp  out  1  sticky trap flag
- State  out  3  current state, for debug
- InstrCount  out  32  retired instructions

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0. IRWrite=PCWrite=iMemReady. Stay in FETCH until iMemReady, then go to DECODE.
- DECODE: classify iInstruction[31:21] into an internal registered class (R, LD, ST, CBZ, B, ILL). ALUSrcA=0, ALUSrcB=11, ALUOp=00 to precompute the branch target. Reg2Loc=1 for ST/CBZ, else 0. Next state is EXEC, or TRAP when the class is ILL.
- EXEC behaviour by class (Reg2Loc holds its DECODE value):
  - R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next WB.
  - LD/ST: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEM.
  - CBZ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. The datapath updates PC when iZero=1. Next FETCH.
  - B: PCWrite=1, PCSource=1; next FETCH.
- MEM: IorD=1. LD asserts MemRead=1; ST asserts MemWrite=1. Strobes are held until iMemReady. On ready, LD goes to WB and ST goes to FETCH.
- WB: RegWrite=1; MemtoReg=1 for LD, 0 for R. Next FETCH.
- TRAP: all strobes 0, IllegalOp=1. TRAP is absorbing; only iRST exits it.
- Outputs not listed for a state are 0.
- InstrCount increments by 1 on every transition into FETCH from EXEC, MEM or WB. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - While iRST=1, all outputs are forced to 0 and no strobe is asserted in that cycle.
  - On the edge, State becomes FETCH, the class register clears, InstrCount=0 and IllegalOp=0.
  - Reset mid-instruction, including mid-MEM, aborts the instruction with no further writes.
- Latency, with zero memory wait: R = 4 cycles, LD = 5, ST = 4, CBZ/B = 3. Each cycle with iMemReady=0 in FETCH or MEM adds exactly 1 cycle.
- iMemReady is ignored outside FETCH and MEM. MemRead/MemWrite must not drop before the ready cycle.
- IRWrite/PCWrite in FETCH are combinational on iMemReady, so they are asserted in the same cycle as ready.
- iInstruction is sampled only in DECODE, so later IR changes do not affect the class.
- IllegalOp rises on the edge that enters TRAP and remains high until iRST.

## Test plan
- Reset: iRST=1 for 2 cycles with iMemReady=1 -> all strobes 0, State=0, InstrCount=0; the first post-reset cycle shows MemRead=1, IRWrite=1.
- ADD 0x8B030041 with ready always 1 -> state trace 0,1,2,4,0; ALUOp=10 in EXEC; RegWrite=1 in WB only; InstrCount=1.
- LDUR 0xF8408041 with ready low for 3 cycles in MEM -> MEM lasts 4 cycles with MemRead held and IorD=1; WB has MemtoReg=1, RegWrite=1; total 8 cycles.
- STUR 0xF8008041 -> MemWrite=1 exactly in MEM, Reg2Loc=1 in DECODE/EXEC, no RegWrite; then CBZ 0xB4000041 -> PCWriteCond=1, PCSource=1 in EXEC, 3 cycles.
- B 0x14000004 with FETCH stalled 2 cycles -> IRWrite pulses only on the ready cycle; PCWrite=1 in EXEC; InstrCount increments once.
- Illegal 0x00000000 -> TRAP after DECODE, IllegalOp=1 held for 10 cycles, InstrCount unchanged; iRST clears it; InstrCount preloaded at 0xFFFFFFFF wraps to 0 on the next retire.
